// File: rtl/rtc_bus_sequencer_if.sv
// rtc_bus_sequencer_if
// Command and pin bundle for the RTC bus sequencer.
// master: the upstream side. It issues commands and supplies the pad value of `salient`.
// slave : the sequencer. It drives the RTC strobes and the tristate drive value and enable.
interface rtc_bus_sequencer_if;
    logic       start_wr;
    logic       start_rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       err;
    logic       err_clr;
    logic       AD;
    logic       CS;
    logic       WR;
    logic       RD;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;

    modport master (
        output start_wr, start_rd, addr, wdata, err_clr, bus_in,
        input  rdata, busy, done, err, AD, CS, WR, RD, bus_out, bus_oe
    );

    modport slave (
        input  start_wr, start_rd, addr, wdata, err_clr, bus_in,
        output rdata, busy, done, err, AD, CS, WR, RD, bus_out, bus_oe
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
// Turns one-cycle read/write pulses into the multiplexed address/data bus cycle
// of the external RTC. Every output comes from a register.
// Optional feature macro: RTC_BUSY_ERR_EN. When it is defined, a start seen while
// busy sets a sticky err flag. When it is not defined, err is tied low.
module rtc_bus_sequencer #(
    parameter int unsigned PHASE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bus_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_SETUP  = 3'd1,
        A_STROBE = 3'd2,
        A_HOLD   = 3'd3,
        D_STROBE = 3'd4,
        D_HOLD   = 3'd5
    } state_t;

    localparam logic [7:0] PHASE_RELOAD = 8'(PHASE_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_is_wr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       r_busy;
    logic       r_done;
    logic       r_ad;
    logic       r_cs;
    logic       r_wr;
    logic       r_rd;
    logic       r_oe;
    logic [7:0] r_bus_out;

    logic       w_start;
    logic       w_phase_end;

    assign w_start     = bus.start_wr | bus.start_rd;
    assign w_phase_end = (r_cnt == 8'd0);

    // Bus-cycle FSM. Each transition also loads the pin values for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_is_wr   <= 1'b0;
            r_wdata   <= 8'h00;
            r_rdata   <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ad      <= 1'b1;
            r_cs      <= 1'b1;
            r_wr      <= 1'b1;
            r_rd      <= 1'b1;
            r_oe      <= 1'b0;
            r_bus_out <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A start is accepted here, including in the done cycle. Write wins a tie.
                    if (w_start) begin
                        r_state   <= A_SETUP;
                        r_cnt     <= 8'd0;
                        r_is_wr   <= bus.start_wr;
                        r_wdata   <= bus.wdata;
                        r_busy    <= 1'b1;
                        r_cs      <= 1'b0;
                        r_ad      <= 1'b0;
                        r_oe      <= 1'b1;
                        r_bus_out <= bus.addr;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                A_SETUP: begin
                    // The address setup phase always lasts a single cycle.
                    r_state <= A_STROBE;
                    r_cnt   <= PHASE_RELOAD;
                    r_wr    <= 1'b0;
                end
                A_STROBE: begin
                    if (w_phase_end) begin
                        r_state <= A_HOLD;
                        r_cnt   <= PHASE_RELOAD;
                        r_wr    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                A_HOLD: begin
                    if (w_phase_end) begin
                        r_state <= D_STROBE;
                        r_cnt   <= PHASE_RELOAD;
                        r_ad    <= 1'b1;
                        if (r_is_wr) begin
                            r_wr      <= 1'b0;
                            r_oe      <= 1'b1;
                            r_bus_out <= r_wdata;
                        end else begin
                            r_rd <= 1'b0;
                            r_oe <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                D_STROBE: begin
                    if (w_phase_end) begin
                        r_state <= D_HOLD;
                        r_cnt   <= PHASE_RELOAD;
                        r_wr    <= 1'b1;
                        r_rd    <= 1'b1;
                        // Capture read data on the edge that closes the strobe.
                        if (!r_is_wr) begin
                            r_rdata <= bus.bus_in;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                D_HOLD: begin
                    if (w_phase_end) begin
                        r_state   <= IDLE;
                        r_cnt     <= 8'd0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_cs      <= 1'b1;
                        r_ad      <= 1'b1;
                        r_oe      <= 1'b0;
                        r_bus_out <= 8'h00;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    // An illegal state releases the bus and returns to idle.
                    r_state   <= IDLE;
                    r_cnt     <= 8'd0;
                    r_busy    <= 1'b0;
                    r_cs      <= 1'b1;
                    r_ad      <= 1'b1;
                    r_wr      <= 1'b1;
                    r_rd      <= 1'b1;
                    r_oe      <= 1'b0;
                    r_bus_out <= 8'h00;
                end
            endcase
        end
    end

`ifdef RTC_BUSY_ERR_EN
    logic r_err;

    // Sticky flag for a start that arrives while busy. Setting it beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_start && r_busy) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.rdata   = r_rdata;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.AD      = r_ad;
    assign bus.CS      = r_cs;
    assign bus.WR      = r_wr;
    assign bus.RD      = r_rd;
    assign bus.bus_out = r_bus_out;
    assign bus.bus_oe  = r_oe;

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Converts single-cycle read/write commands from the PicoBlaze port logic into the multiplexed address/data bus cycle required by the external real-time clock (active-low AD, CS, WR, RD plus the shared 8-bit `salient` bus). It sits directly downstream of the PicoBlaze I/O decode inside `TOP_PicoBalze` and directly drives the chip's RTC pins. The tristate buffer for `salient` lives in the top level; this block only supplies drive value, output enable and sampled input.

## Interface
- `PHASE_CYCLES`, 4: clock cycles per strobe/hold phase; legal range 1..255.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start_wr`  in  1  one-cycle pulse; starts a write cycle.
- `start_rd`  in  1  one-cycle pulse; starts a read cycle.
- `addr`  in  8  RTC register address, sampled with start.
- `wdata`  in  8  write data, sampled with start.
- `rdata`  out  8  last read result.
- `busy`  out  1  high while a bus cycle is in progress.
- `done`  out  1  one-cycle pulse at cycle completion.
- `err`  out  1  sticky command-while-busy flag (see Configuration).
- `err_clr`  in  1  clears `err`.
- `AD`  out  1  address(0)/data(1) select.
- `CS`  out  1  chip select, active low.
- `WR`  out  1  write strobe, active low.
- `RD`  out  1  read strobe, active low.
- `bus_out`  out  8  value to drive on `salient`.
- `bus_oe`  out  1  high = drive `salient` with `bus_out`.
- `bus_in`  in  8  `salient` as seen at the pad.

## Operation
- Reset values: AD=1, CS=1, WR=1, RD=1, bus_oe=0, bus_out=0x00, rdata=0x00, busy=0, done=0, err=0.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, D_STROBE, D_HOLD.
- IDLE: all strobes high, bus_oe=0. On start_wr or start_rd: latch addr, wdata, direction; go A_SETUP. If both are high in the same cycle, the write is taken and the read is dropped.
- A_SETUP (1 cycle): CS=0, AD=0, bus_oe=1, bus_out=addr.
- A_STROBE (T cycles): as A_SETUP, plus WR=0.
- A_HOLD (T cycles): WR=1; address is still driven.
- D_STROBE (T cycles): AD=1. Write: WR=0, bus_oe=1, bus_out=wdata. Read: RD=0, bus_oe=0. `rdata` is loaded from `bus_in` on the clock edge that ends the last D_STROBE cycle.
- D_HOLD (T cycles): WR=RD=1. Write data is still driven; for a read, bus_oe=0.
- After D_HOLD: CS=1, AD=1, bus_oe=0. Return to IDLE with done=1 for that single IDLE cycle.
- The phase counter reloads to T-1 on every state entry and advances state at 0.
- Starts while busy=1 are ignored; the cycle in flight is never disturbed. A start arriving in the done cycle is accepted.
- Reset mid-cycle: on the next edge all outputs take their reset values, the bus is released, no done is issued, and rdata is cleared.

## Timing
- Start sampled at edge of cycle 0. A_SETUP = cycle 1; A_STROBE = 2..T+1; A_HOLD = T+2..2T+1; D_STROBE = 2T+2..3T+1; D_HOLD = 3T+2..4T+1; done = cycle 4T+2.
- busy is high for cycles 1..4T+1 (4T+1 cycles). Back-to-back commands are possible: the next command may start in cycle 4T+2, which gives a minimum command period of 4T+2.
- For a read, rdata is valid from cycle 3T+2 and held until the next read completes.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Defaults (T=4): done at cycle 18, rdata valid at cycle 14.

## Configuration
- `RTC_BUSY_ERR_EN` defined: a start_wr or start_rd seen while busy=1 sets err=1 on the next edge. err stays high until err_clr=1 or reset. If err_clr and a new violation occur in the same cycle, set wins.
- Not defined: err is tied to 0, err_clr is ignored, and starts during busy are silently dropped.

## Test plan
- Write, T=4: start_wr with addr=0x21, wdata=0x15. Required: AD=0, bus_out=0x21 in cycles 1..9, with WR low in cycles 2..5. Then AD=1, bus_out=0x15, WR low in cycles 10..13. done=1 at cycle 18; CS high again in cycle 18.
- Read, T=4: start_rd with addr=0x41, bus_in=0x37 during D_STROBE. Required: RD low in cycles 10..13 with bus_oe=0; rdata=0x37 from cycle 14; done at cycle 18.
- Simultaneous/busy: start_wr and start_rd in the same cycle runs a write only. A start_rd at cycle 6 is ignored, and with `RTC_BUSY_ERR_EN` err=1 from cycle 7. err_clr then returns err to 0.
- Reset mid-operation: reset asserted in cycle 11 of a write. Required: next cycle CS=WR=RD=AD=1, bus_oe=0, busy=0, and no done pulse. A new start_wr afterwards completes normally.
- Boundary T=1: a write completes with done at cycle 6. A back-to-back start_rd in cycle 6 is accepted, with busy=1 from cycle 7.
